// File: rtl/rgb_fade_pkg.sv
// Shared types and palette for the RGB level controller.
// No logic, so no latency or backpressure.
package rgb_fade_pkg;

    localparam int LVL_W       = 8;
    localparam int MAX_PRESETS = 4;

    typedef logic [LVL_W-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        FADE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Entry order within a preset is R, G, B.
    localparam level_t PALETTE [MAX_PRESETS][3] = '{
        '{8'hFF, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h00},
        '{8'h00, 8'h00, 8'hFF},
        '{8'hFF, 8'hFF, 8'hFF}
    };

endpackage

// File: rtl/rgb_fade_step.sv
// One channel: move the level one count toward its target; flag when it lands there.
// Combinational, no backpressure.
module rgb_fade_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_tgt,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_reached
);

    // Moving only toward the target means 0 and all-ones can never wrap.
    always_comb begin
        o_nxt = i_cur;
        if (i_cur < i_tgt) begin
            o_nxt = i_cur + WIDTH'(1);
        end else if (i_cur > i_tgt) begin
            o_nxt = i_cur - WIDTH'(1);
        end
    end

    assign o_reached = (o_nxt == i_tgt);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Picks per-channel PWM levels (manual or palette fade), committed only at PWM wrap.
// pwm_sync->lvl 1 clk, 2 clk with RGB_FADE_CTRL_GAMMA_EN (gamma curve); no backpressure.
module rgb_fade_ctrl
    import rgb_fade_pkg::*;
#(
    parameter int WIDTH       = LVL_W,
    parameter int TICK_DIV    = 16384,
    parameter int HOLD_TICKS  = 64,
    parameter int NUM_PRESETS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode_auto,
    input  logic [WIDTH-1:0] man_lvl0,
    input  logic [WIDTH-1:0] man_lvl1,
    input  logic [WIDTH-1:0] man_lvl2,
    input  logic             pwm_sync,
    output logic [WIDTH-1:0] lvl0,
    output logic [WIDTH-1:0] lvl1,
    output logic [WIDTH-1:0] lvl2,
    output logic             commit,
    output logic [1:0]       state,
    output logic [1:0]       preset_idx
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_presc;
    logic [HW-1:0]    r_hold, w_hold_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_work [3];
    logic [WIDTH-1:0] w_work_nxt [3];
    logic [WIDTH-1:0] w_step [3];
    logic [WIDTH-1:0] w_man [3];
    logic [WIDTH-1:0] w_tgt [3];
    logic [WIDTH-1:0] r_lvl [3];
    logic [2:0]       w_reached;
    logic             w_fading, w_tick, r_commit;

    assign w_man[0] = man_lvl0;
    assign w_man[1] = man_lvl1;
    assign w_man[2] = man_lvl2;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_ch
        assign w_tgt[g] = WIDTH'(PALETTE[r_idx][g]);
        rgb_fade_step #(.WIDTH(WIDTH)) u_step (
            .i_cur     (r_work[g]),
            .i_tgt     (w_tgt[g]),
            .o_nxt     (w_step[g]),
            .o_reached (w_reached[g])
        );
    end

    assign w_fading = (r_state == FADE) || (r_state == HOLD);
    assign w_tick   = w_fading && (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!w_fading || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            for (int c = 0; c < 3; c++) r_work[c] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            for (int c = 0; c < 3; c++) r_work[c] <= w_work_nxt[c];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        for (int c = 0; c < 3; c++) w_work_nxt[c] = r_work[c];

        if (!enable) begin
            w_state_nxt = IDLE;
        end else if (!mode_auto) begin
            w_state_nxt = MANUAL;
            for (int c = 0; c < 3; c++) w_work_nxt[c] = w_man[c];
        end else begin
            case (r_state)
                IDLE, MANUAL: begin
                    // Resume fading from wherever the working levels were left.
                    w_state_nxt = FADE;
                    w_hold_nxt  = '0;
                end
                FADE: begin
                    if (w_tick) begin
                        for (int c = 0; c < 3; c++) w_work_nxt[c] = w_step[c];
                        if (&w_reached) begin
                            w_state_nxt = HOLD;
                            w_hold_nxt  = '0;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        if (r_hold == HW'(HOLD_TICKS - 1)) begin
                            w_idx_nxt   = (r_idx + 2'd1) & 2'(NUM_PRESETS - 1);
                            w_hold_nxt  = '0;
                            w_state_nxt = FADE;
                        end else begin
                            w_hold_nxt = r_hold + HW'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef RGB_FADE_CTRL_GAMMA_EN
    logic [WIDTH-1:0] r_gwork [3];
    logic             r_gvld;

    function automatic logic [WIDTH-1:0] gamma(input logic [WIDTH-1:0] x);
        logic [2*WIDTH-1:0] sq;
        sq = (2*WIDTH)'(x) * (2*WIDTH)'(x);
        return sq[2*WIDTH-1:WIDTH];
    endfunction

    // Capture stage keeps the pre-update working levels; the square is taken one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gvld   <= 1'b0;
            r_commit <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                r_gwork[c] <= '0;
                r_lvl[c]   <= '0;
            end
        end else begin
            r_gvld   <= pwm_sync;
            r_commit <= r_gvld;
            for (int c = 0; c < 3; c++) begin
                if (pwm_sync) r_gwork[c] <= r_work[c];
                if (r_gvld)   r_lvl[c]   <= gamma(r_gwork[c]);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit <= 1'b0;
            for (int c = 0; c < 3; c++) r_lvl[c] <= '0;
        end else begin
            r_commit <= pwm_sync;
            if (pwm_sync) begin
                for (int c = 0; c < 3; c++) r_lvl[c] <= r_work[c];
            end
        end
    end
`endif

    assign lvl0       = r_lvl[0];
    assign lvl1       = r_lvl[1];
    assign lvl2       = r_lvl[2];
    assign commit     = r_commit;
    assign state      = r_state;
    assign preset_idx = r_idx;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Randomized bench for rgb_fade_ctrl with a behavioural model and a commit scoreboard.
module tb_rgb_fade_ctrl;

    localparam int TD = 4;
    localparam int HT = 2;
    localparam int NP = 4;
`ifdef RGB_FADE_CTRL_GAMMA_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, enable, mode_auto, pwm_sync, commit;
    logic [7:0] man_lvl0, man_lvl1, man_lvl2, lvl0, lvl1, lvl2;
    logic [1:0] state, preset_idx;

    rgb_fade_ctrl #(.WIDTH(8), .TICK_DIV(TD), .HOLD_TICKS(HT), .NUM_PRESETS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode_auto(mode_auto),
        .man_lvl0(man_lvl0), .man_lvl1(man_lvl1), .man_lvl2(man_lvl2),
        .pwm_sync(pwm_sync), .lvl0(lvl0), .lvl1(lvl1), .lvl2(lvl2),
        .commit(commit), .state(state), .preset_idx(preset_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   nchecks = 0;
    int   nerrs   = 0;
    int   cyc     = 0;

    // Behavioural model: state 0 idle, 1 manual, 2 fade, 3 hold.
    int m_state, m_idx, m_presc, m_hold;
    int m_work [3];

    // Preset k lights channel k; preset 3 lights all three.
    function automatic int target(input int idx, input int c);
        return (idx == 3 || idx == c) ? 255 : 0;
    endfunction

    function automatic int shape(input int v);
`ifdef RGB_FADE_CTRL_GAMMA_EN
        return (v * v) / 256;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_presc = 0; m_hold = 0;
        for (int c = 0; c < 3; c++) m_work[c] = 0;
    endtask

    // Advance model and DUT one clock with the inputs currently driven.
    task automatic step();
        int  ns;
        int  nw [3];
        int  man [3];
        bit  tick;
        bit  all_eq;
        exp_t e;
        man[0] = man_lvl0; man[1] = man_lvl1; man[2] = man_lvl2;
        tick = (m_state >= 2) && (m_presc == TD - 1);
        if (pwm_sync) begin
            e.due = 32'(cyc + LAT);
            e.r = 8'(shape(m_work[0]));
            e.g = 8'(shape(m_work[1]));
            e.b = 8'(shape(m_work[2]));
            q.push_back(e);
        end
        ns = m_state;
        nw = m_work;
        if (!enable) begin
            ns = 0;
        end else if (!mode_auto) begin
            ns = 1;
            nw = man;
        end else if (m_state < 2) begin
            ns = 2;
            m_hold = 0;
        end else if (tick && m_state == 2) begin
            all_eq = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (nw[c] < target(m_idx, c)) nw[c] = nw[c] + 1;
                else if (nw[c] > target(m_idx, c)) nw[c] = nw[c] - 1;
                if (nw[c] != target(m_idx, c)) all_eq = 1'b0;
            end
            if (all_eq) begin
                ns = 3;
                m_hold = 0;
            end
        end else if (tick) begin
            if (m_hold == HT - 1) begin
                m_idx = (m_idx + 1) % NP;
                m_hold = 0;
                ns = 2;
            end else begin
                m_hold = m_hold + 1;
            end
        end
        m_presc = (m_state >= 2) ? (tick ? 0 : m_presc + 1) : 0;
        m_state = ns;
        m_work  = nw;
        @(posedge clk);
        #1;
        cyc++;
        check("state", int'(state), m_state);
        check("preset_idx", int'(preset_idx), m_idx);
    endtask

    task automatic set_man(input int a, input int b, input int c);
        man_lvl0 = 8'(a); man_lvl1 = 8'(b); man_lvl2 = 8'(c);
    endtask

    // Drain pending commits, then assert reset between clock edges.
    task automatic do_reset();
        pwm_sync = 1'b0;
        repeat (LAT + 1) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_lvl0", int'(lvl0), 0);
        check("rst_lvl1", int'(lvl1), 0);
        check("rst_lvl2", int'(lvl2), 0);
        check("rst_state", int'(state), 0);
        check("rst_preset_idx", int'(preset_idx), 0);
        check("rst_commit", int'(commit), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && commit) begin
            if (q.size() == 0) begin
                nchecks++;
                nerrs++;
                $display("FAIL spurious_commit: got commit=1 expected no pending commit (cycle %0d)", cyc);
            end else begin
                e_mon = q.pop_front();
                check("commit_latency", cyc, int'(e_mon.due));
                check("lvl0", int'(lvl0), int'(e_mon.r));
                check("lvl1", int'(lvl1), int'(e_mon.g));
                check("lvl2", int'(lvl2), int'(e_mon.b));
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode_auto = 1'b0; pwm_sync = 1'b0;
        set_man(0, 0, 0);
        model_reset();
        #2;
        check("init_lvl0", int'(lvl0), 0);
        check("init_state", int'(state), 0);
        check("init_preset_idx", int'(preset_idx), 0);
        check("init_commit", int'(commit), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Manual levels must not reach the outputs without pwm_sync.
        enable = 1'b1; mode_auto = 1'b0;
        set_man('h12, 'h34, 'h56);
        repeat (5) begin
            step();
            check("hold_lvl0", int'(lvl0), 0);
            check("hold_lvl1", int'(lvl1), 0);
            check("hold_lvl2", int'(lvl2), 0);
        end
        pwm_sync = 1'b1;
        step();
        pwm_sync = 1'b0;
        repeat (3) step();
        check("manual_lvl0", int'(lvl0), shape('h12));
        check("manual_lvl2", int'(lvl2), shape('h56));

        // Full fade to red from reset, then hold and advance to preset 1.
        do_reset();
        enable = 1'b1; mode_auto = 1'b1;
        set_man($urandom_range(255), $urandom_range(255), $urandom_range(255));
        step();
        repeat (1020) begin
            pwm_sync = ($urandom_range(7) == 0);
            step();
        end
        pwm_sync = 1'b0;
        check("hold_after_255_ticks", int'(state), 3);
        pwm_sync = 1'b1;
        step();
        pwm_sync = 1'b0;
        repeat (7) step();
        check("fade_after_hold_state", int'(state), 2);
        check("fade_after_hold_idx", int'(preset_idx), 1);

        // Channels already at their targets (one at FF, two at 00): first tick holds.
        do_reset();
        enable = 1'b1; mode_auto = 1'b0;
        set_man('hFF, 'h00, 'h00);
        repeat (2) step();
        mode_auto = 1'b1;
        step();
        repeat (4) step();
        check("hold_first_tick", int'(state), 3);
        pwm_sync = 1'b1;
        step();
        pwm_sync = 1'b0;

        // Leave auto mid-fade at red=80, commit on the switching cycle, then resume.
        do_reset();
        enable = 1'b1; mode_auto = 1'b1;
        set_man('h10, 'h20, 'h30);
        repeat (513) step();
        mode_auto = 1'b0; pwm_sync = 1'b1;
        step();
        check("manual_after_toggle", int'(state), 1);
        step();
        pwm_sync = 1'b0;
        step();
        mode_auto = 1'b1;
        repeat (10) step();
        check("resume_fade", int'(state), 2);
        check("resume_idx", int'(preset_idx), 0);

        // Random traffic; ends with a reset taken mid-run.
        do_reset();
        enable = 1'b1; mode_auto = 1'b1;
        repeat (4000) begin
            if ($urandom_range(99) == 0) enable = ~enable;
            if ($urandom_range(149) == 0) mode_auto = ~mode_auto;
            if ($urandom_range(15) == 0)
                set_man($urandom_range(255), $urandom_range(255), $urandom_range(255));
            pwm_sync = ($urandom_range(5) == 0);
            step();
        end
        do_reset();
        pwm_sync = 1'b0;
        repeat (4) step();
        check("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
Level controller sitting between the quadrature-encoder front end and the three PWM channels of the RGB mixer. It decides each channel's 8-bit duty level.
- Manual mode: levels come from the encoder counters.
- Auto mode: levels fade through a fixed palette of preset colours.
Committed levels change only at PWM period boundaries, so no channel glitches mid-period.

Parameters:
WIDTH, 8, level width per channel
TICK_DIV, 16384, clocks per fade step (prescaler modulus, >=2)
HOLD_TICKS, 64, fade steps spent holding a reached preset (>=1)
NUM_PRESETS, 4, palette entries, power of two, <=4

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  controller enable; 0 freezes working levels
mode_auto  in  1  1=palette fade, 0=manual
man_lvl0  in  WIDTH  manual level, red (encoder 0 counter)
man_lvl1  in  WIDTH  manual level, green (encoder 1 counter)
man_lvl2  in  WIDTH  manual level, blue (encoder 2 counter)
pwm_sync  in  1  one-cycle pulse at PWM counter wrap
lvl0  out  WIDTH  committed level to PWM 0
lvl1  out  WIDTH  committed level to PWM 1
lvl2  out  WIDTH  committed level to PWM 2
commit  out  1  pulses the cycle lvl* update
state  out  2  0=IDLE 1=MANUAL 2=FADE 3=HOLD
preset_idx  out  2  current palette target

Behaviour:
Clock and reset:
- Single clock clk. Reset is asynchronous and active-low: rst_n.
- Reset values: lvl0..2=0, working levels=0, commit=0, state=IDLE, preset_idx=0, prescaler=0, hold_cnt=0.

Prescaler:
- Counts 0..TICK_DIV-1 only in FADE/HOLD. tick=1 on the cycle it equals TICK_DIV-1, then it wraps to 0.
- Cleared to 0 in any other state.

State machine, priority top to bottom:
- enable=0 -> IDLE from any state. Working levels and preset_idx hold.
- enable=1, mode_auto=0 -> MANUAL. Each cycle, work_n <= man_lvl_n.
- enable=1, mode_auto=1, from IDLE/MANUAL -> FADE. Resumes at the current preset_idx, starting from the current working levels.
- FADE, on tick: each channel independently steps +1 toward target if below, -1 if above, unchanged if equal.
  - If every channel equals target after the step -> HOLD, hold_cnt=0.
  - If all channels already equal target on entry, the first tick goes to HOLD.
- HOLD, on tick: hold_cnt++. When hold_cnt==HOLD_TICKS-1 on a tick: preset_idx <= (preset_idx+1) mod NUM_PRESETS, hold_cnt=0, -> FADE.
- Mode change mid-fade or mid-hold takes effect the next cycle. The partially faded working level is kept until overwritten.

Arithmetic:
- Steps are unsigned ±1 and never wrap. A channel at 0 or 2^WIDTH-1 only moves toward its target.

Commit:
- On a cycle with pwm_sync=1, lvl_n <= work_n and commit=1 the next cycle. Latency from pwm_sync to lvl update is 1 clk.
- Without pwm_sync, lvl_n hold regardless of working levels.
- pwm_sync in IDLE still commits the frozen working levels.
- pwm_sync coinciding with a working-level update commits the pre-update value.

Palette (in package), index: R,G,B:
0: FF,00,00
1: 00,FF,00
2: 00,00,FF
3: FF,FF,FF

Optional Feature:
Macro RGB_FADE_CTRL_GAMMA_EN.
- Defined: committed outputs are gamma-corrected, lvl_n = (work_n*work_n) >> WIDTH. One extra pipeline register is added, so pwm_sync-to-lvl latency is 2 clk and commit is delayed to match.
- Undefined: linear pass-through, 1 clk latency.

Decomposition:
- Package rgb_fade_pkg:
  - state enum IDLE/MANUAL/FADE/HOLD
  - palette constant array
  - level typedef sized by WIDTH
- One sub-module, rgb_fade_step: combinational per-channel ±1-toward-target stepper with a reached flag. Instantiated three times.
- Prescaler, FSM and commit registers stay in the top block.

Test Plan:
- Reset asserted mid-FADE (TICK_DIV=4) -> lvl0..2=0, state=0, preset_idx=0 immediately, without waiting for a clk edge.
- MANUAL, man_lvl=12/34/56 hex, no pwm_sync -> lvl unchanged. Pulse pwm_sync -> lvl=12/34/56 and commit=1 exactly 1 clk later.
- Auto mode from reset, TICK_DIV=4, HOLD_TICKS=2 -> red work level reaches FF after 255 ticks (1020 clk). Then HOLD for 2 ticks, then preset_idx=1 and state=FADE.
- Channel at 00 with target 00 and another at FF with target FF -> no wrap. State goes to HOLD on the first tick.
- Toggle mode_auto 1->0 mid-FADE (work red=80) -> next cycle state=MANUAL, work follows man_lvl. Re-enter auto -> resumes the same preset_idx.
- Gamma build, work=80 hex, pwm_sync -> lvl=40 hex after 2 clk.
